// File: rtl/jogo_memoria_param_if.sv
// -----------------------------------------------------------------------------
// jogo_memoria_param_if
// Bundle of the player-facing and debug signals of the memory-game controller.
//   master : board/testbench side, drives iniciar, botoes, timeout_en and
//            observes the game status and debug outputs.
//   slave  : controller side, the mirror image of master.
// Clock and reset are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface jogo_memoria_param_if #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16
);
  localparam int AW = $clog2(PROFUNDIDADE);

  logic                iniciar;
  logic [N_BOTOES-1:0] botoes;
  logic                timeout_en;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [N_BOTOES-1:0] leds;
  logic [3:0]          db_estado;
  logic [AW-1:0]       db_rodada;
  logic [AW-1:0]       db_endereco;
  logic                db_timeout;

  modport master (
    output iniciar, botoes, timeout_en,
    input  ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_endereco, db_timeout
  );

  modport slave (
    input  iniciar, botoes, timeout_en,
    output ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_endereco, db_timeout
  );
endinterface

// File: rtl/jogo_memoria_param.sv
// -----------------------------------------------------------------------------
// jogo_memoria_param
// Memory-game controller: the player grows a sequence by one play per round
// and must first repeat every stored play. Holds the sequence RAM, the round
// and compare-address counters, the button edge detector, the idle timeout
// counter and the control FSM.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : slave side of jogo_memoria_param_if
//            in : iniciar (start/restart), botoes (buttons), timeout_en
//            out: ganhou, perdeu, pronto, leds (last accepted play),
//                 db_estado, db_rodada, db_endereco, db_timeout
// -----------------------------------------------------------------------------
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic                  clock,
  input logic                  reset,
  jogo_memoria_param_if.slave  bus
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [AW-1:0] ULTIMA_RODADA = AW'(PROFUNDIDADE - 1);
  localparam logic [TW-1:0] TIMER_MAX     = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL         = 4'h0,
    PREPARA         = 4'h1,
    ESPERA_PRIMEIRA = 4'h2,
    GRAVA_PRIMEIRA  = 4'h3,
    ESPERA_JOGADA   = 4'h4,
    COMPARA         = 4'h5,
    ESPERA_NOVA     = 4'h7,
    GRAVA_NOVA      = 4'h8,
    PROX_RODADA     = 4'h9,
    FIM_GANHOU      = 4'hA,
    FIM_PERDEU      = 4'hE,
    FIM_TIMEOUT     = 4'hF
  } estado_e;

  estado_e             estado_q, estado_d;
  logic [N_BOTOES-1:0] botoes_reg_q;
  logic                prev_q;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [N_BOTOES-1:0] leds_q, leds_d;
  logic [AW-1:0]       rodada_q, rodada_d;
  logic [AW-1:0]       endereco_q, endereco_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                ganhou_q, ganhou_d;
  logic                perdeu_q, perdeu_d;
  logic                pronto_q, pronto_d;
  logic                db_timeout_q, db_timeout_d;

  logic [N_BOTOES-1:0] mem_q [PROFUNDIDADE];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;

  logic evento;
  logic em_espera;
  logic expirou;
  logic igual;

  // Rising edge of "any button pressed"; a held button yields one event.
  assign evento    = (|botoes_reg_q) & ~prev_q;
  assign em_espera = (estado_q == ESPERA_PRIMEIRA) || (estado_q == ESPERA_JOGADA) ||
                     (estado_q == ESPERA_NOVA);
  // An event in the expiry cycle wins over the timeout.
  assign expirou   = bus.timeout_en && (timer_q == TIMER_MAX) && !evento;
  assign igual     = (jogada_q == mem_q[endereco_q]);

  // Button synchroniser and edge-detector history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes_reg_q <= '0;
      prev_q       <= 1'b0;
    end else begin
      botoes_reg_q <= bus.botoes;
      prev_q       <= |botoes_reg_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:         estado_d = bus.iniciar ? PREPARA : INICIAL;
      PREPARA:         estado_d = ESPERA_PRIMEIRA;
      ESPERA_PRIMEIRA: begin
        if (evento)       estado_d = GRAVA_PRIMEIRA;
        else if (expirou) estado_d = FIM_TIMEOUT;
        else              estado_d = ESPERA_PRIMEIRA;
      end
      GRAVA_PRIMEIRA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:   begin
        if (evento)       estado_d = COMPARA;
        else if (expirou) estado_d = FIM_TIMEOUT;
        else              estado_d = ESPERA_JOGADA;
      end
      COMPARA:         begin
        if (!igual)                         estado_d = FIM_PERDEU;
        else if (endereco_q < rodada_q)     estado_d = ESPERA_JOGADA;
        else if (rodada_q == ULTIMA_RODADA) estado_d = FIM_GANHOU;
        else                                estado_d = ESPERA_NOVA;
      end
      ESPERA_NOVA:     begin
        if (evento)       estado_d = GRAVA_NOVA;
        else if (expirou) estado_d = FIM_TIMEOUT;
        else              estado_d = ESPERA_NOVA;
      end
      GRAVA_NOVA:      estado_d = PROX_RODADA;
      PROX_RODADA:     estado_d = ESPERA_JOGADA;
      FIM_GANHOU,
      FIM_PERDEU,
      FIM_TIMEOUT:     estado_d = bus.iniciar ? PREPARA : estado_q;
      default:         estado_d = INICIAL;
    endcase
  end

  // Datapath next values: counters, captured play, LEDs, RAM write, timer.
  always_comb begin
    jogada_d   = jogada_q;
    leds_d     = leds_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;

    // The timer restarts on every entry into a wait state and only runs while
    // the same wait state is kept with the timeout enabled.
    if (em_espera && (estado_d == estado_q) && bus.timeout_en) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end

    case (estado_q)
      PREPARA: begin
        rodada_d   = '0;
        endereco_d = '0;
        leds_d     = '0;
        jogada_d   = '0;
      end
      ESPERA_PRIMEIRA,
      ESPERA_JOGADA,
      ESPERA_NOVA: begin
        if (evento) begin
          jogada_d = botoes_reg_q;
          leds_d   = botoes_reg_q;
        end else begin
          jogada_d = jogada_q;
          leds_d   = leds_q;
        end
      end
      GRAVA_PRIMEIRA: begin
        mem_we    = 1'b1;
        mem_waddr = '0;
      end
      COMPARA: begin
        if (igual && (endereco_q < rodada_q)) begin
          endereco_d = endereco_q + AW'(1);
        end else begin
          endereco_d = endereco_q;
        end
      end
      GRAVA_NOVA: begin
        // Only reached while rodada < P-1, so the increment cannot wrap.
        mem_we    = 1'b1;
        mem_waddr = rodada_q + AW'(1);
      end
      PROX_RODADA: begin
        rodada_d   = rodada_q + AW'(1);
        endereco_d = '0;
      end
      default: begin
        jogada_d = jogada_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada_q   <= '0;
      leds_q     <= '0;
      rodada_q   <= '0;
      endereco_q <= '0;
      timer_q    <= '0;
    end else begin
      jogada_q   <= jogada_d;
      leds_q     <= leds_d;
      rodada_q   <= rodada_d;
      endereco_q <= endereco_d;
      timer_q    <= timer_d;
    end
  end

  // Sequence RAM; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= jogada_q;
    end
  end

  // FSM output decode from the next state so the flags register in step with
  // the state code.
  always_comb begin
    ganhou_d     = 1'b0;
    perdeu_d     = 1'b0;
    pronto_d     = 1'b0;
    db_timeout_d = 1'b0;
    case (estado_d)
      FIM_GANHOU: begin
        ganhou_d = 1'b1;
        pronto_d = 1'b1;
      end
      FIM_PERDEU: begin
        perdeu_d = 1'b1;
        pronto_d = 1'b1;
      end
      FIM_TIMEOUT: begin
        perdeu_d     = 1'b1;
        pronto_d     = 1'b1;
        db_timeout_d = 1'b1;
      end
      default: begin
        pronto_d = 1'b0;
      end
    endcase
  end

  // Status flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ganhou_q     <= 1'b0;
      perdeu_q     <= 1'b0;
      pronto_q     <= 1'b0;
      db_timeout_q <= 1'b0;
    end else begin
      ganhou_q     <= ganhou_d;
      perdeu_q     <= perdeu_d;
      pronto_q     <= pronto_d;
      db_timeout_q <= db_timeout_d;
    end
  end

  assign bus.ganhou      = ganhou_q;
  assign bus.perdeu      = perdeu_q;
  assign bus.pronto      = pronto_q;
  assign bus.db_timeout  = db_timeout_q;
  assign bus.leds        = leds_q;
  assign bus.db_estado   = estado_q;
  assign bus.db_rodada   = rodada_q;
  assign bus.db_endereco = endereco_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// -----------------------------------------------------------------------------
// tb_jogo_memoria_param
// Self-checking bench for jogo_memoria_param with N=4, P=4, TIMEOUT=100.
// A table of plays with the expected post-play state is replayed through a
// scoreboard queue; hand-written sequences cover reset, timeout and holds.
// -----------------------------------------------------------------------------
module tb_jogo_memoria_param;
  localparam int N = 4;
  localparam int P = 4;
  localparam int T = 100;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  jogo_memoria_param_if #(.N_BOTOES(N), .PROFUNDIDADE(P)) bus ();

  jogo_memoria_param #(.N_BOTOES(N), .PROFUNDIDADE(P), .TIMEOUT_CICLOS(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic [3:0] estado;
    logic [1:0] rod;
    logic [1:0] ender;
    logic [3:0] leds;
  } vec_t;

  vec_t tbl [14];
  vec_t sb_q [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // {ganhou, perdeu, pronto, db_timeout} expected for a given state code
  function automatic logic [3:0] flags_for(input logic [3:0] est);
    case (est)
      4'hA:    return 4'b1010;
      4'hE:    return 4'b0110;
      4'hF:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string name, input logic [3:0] est);
    chk(name, {28'd0, bus.ganhou, bus.perdeu, bus.pronto, bus.db_timeout}, {28'd0, flags_for(est)});
  endtask

  task automatic cmp_vec(input string tag, input vec_t e);
    chk({tag, "_estado"}, {28'd0, bus.db_estado}, {28'd0, e.estado});
    chk({tag, "_rodada"}, {30'd0, bus.db_rodada}, {30'd0, e.rod});
    chk({tag, "_endereco"}, {30'd0, bus.db_endereco}, {30'd0, e.ender});
    chk({tag, "_leds"}, {28'd0, bus.leds}, {28'd0, e.leds});
    chk_flags({tag, "_flags"}, e.estado);
  endtask

  // One press sampled at edge t; outcome checked after edge t+2.
  task automatic play(input vec_t v, input string tag);
    vec_t e;
    repeat (3) @(negedge clock);
    sb_q.push_back(v);
    bus.botoes = v.btn;
    @(posedge clock);
    @(negedge clock);
    bus.botoes = 4'b0000;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    e = sb_q.pop_front();
    cmp_vec(tag, e);
  endtask

  task automatic play_range(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      play(tbl[i], $sformatf("%s%0d", tag, i));
    end
  endtask

  task automatic start_game(input string tag);
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk({tag, "_prepara"}, {28'd0, bus.db_estado}, 32'h1);
    chk_flags({tag, "_prep_flags"}, 4'h1);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_espera1"}, {28'd0, bus.db_estado}, 32'h2);
    chk({tag, "_leds0"}, {28'd0, bus.leds}, 32'h0);
    chk({tag, "_rod0"}, {30'd0, bus.db_rodada}, 32'h0);
    chk({tag, "_end0"}, {30'd0, bus.db_endereco}, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_estado", {28'd0, bus.db_estado}, 32'h0);
    chk("rst_async_leds", {28'd0, bus.leds}, 32'h0);
    chk("rst_async_rodada", {30'd0, bus.db_rodada}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    vec_t lose_v;
    tbl[0]  = '{4'b0001, 4'h4, 2'd0, 2'd0, 4'b0001};
    tbl[1]  = '{4'b0001, 4'h7, 2'd0, 2'd0, 4'b0001};
    tbl[2]  = '{4'b0010, 4'h9, 2'd0, 2'd0, 4'b0010};
    tbl[3]  = '{4'b0001, 4'h4, 2'd1, 2'd1, 4'b0001};
    tbl[4]  = '{4'b0010, 4'h7, 2'd1, 2'd1, 4'b0010};
    tbl[5]  = '{4'b0100, 4'h9, 2'd1, 2'd1, 4'b0100};
    tbl[6]  = '{4'b0001, 4'h4, 2'd2, 2'd1, 4'b0001};
    tbl[7]  = '{4'b0010, 4'h4, 2'd2, 2'd2, 4'b0010};
    tbl[8]  = '{4'b0100, 4'h7, 2'd2, 2'd2, 4'b0100};
    tbl[9]  = '{4'b1000, 4'h9, 2'd2, 2'd2, 4'b1000};
    tbl[10] = '{4'b0001, 4'h4, 2'd3, 2'd1, 4'b0001};
    tbl[11] = '{4'b0010, 4'h4, 2'd3, 2'd2, 4'b0010};
    tbl[12] = '{4'b0100, 4'h4, 2'd3, 2'd3, 4'b0100};
    tbl[13] = '{4'b1000, 4'hA, 2'd3, 2'd3, 4'b1000};
    lose_v  = '{4'b0100, 4'hE, 2'd1, 2'd1, 4'b0100};

    bus.iniciar    = 1'b0;
    bus.botoes     = 4'b0000;
    bus.timeout_en = 1'b1;

    // 1. Reset state, reset while idle, reset mid-game.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_estado", {28'd0, bus.db_estado}, 32'h0);
    chk_flags("reset_flags", 4'h0);
    chk("reset_leds", {28'd0, bus.leds}, 32'h0);
    pulse_reset();
    start_game("g0");
    play(tbl[0], "g0_first");
    chk("pre_rst_estado", {28'd0, bus.db_estado}, 32'h4);
    pulse_reset();

    // 2. Full winning game.
    start_game("win");
    play_range(0, 13, "win");

    // 3. Wrong play in round 1 from a restart out of FIM_GANHOU.
    start_game("lose");
    play_range(0, 3, "lose");
    play(lose_v, "lose_bad");

    // 6. Restart from FIM_PERDEU, then a complete winning game.
    start_game("rst6");
    play_range(0, 13, "win2");

    // 4. Timeout exactly 100 cycles after entering ESPERA_NOVA.
    start_game("to");
    play_range(0, 4, "to");
    repeat (99) @(posedge clock);
    @(negedge clock);
    chk("to_before_expiry", {28'd0, bus.db_estado}, 32'h7);
    chk_flags("to_before_flags", 4'h7);
    @(posedge clock);
    @(negedge clock);
    chk("to_expired", {28'd0, bus.db_estado}, 32'hF);
    chk_flags("to_expired_flags", 4'hF);

    // 4b. Press landing on the expiry cycle is accepted.
    start_game("tp");
    play_range(0, 4, "tp");
    repeat (98) @(posedge clock);
    @(negedge clock);
    bus.botoes = 4'b0100;
    @(posedge clock);
    @(negedge clock);
    bus.botoes = 4'b0000;
    @(posedge clock);
    @(negedge clock);
    chk("tp_accept_estado", {28'd0, bus.db_estado}, 32'h8);
    chk("tp_accept_leds", {28'd0, bus.leds}, 32'h4);
    chk_flags("tp_accept_flags", 4'h8);
    repeat (2) @(negedge clock);
    chk("tp_next_round", {30'd0, bus.db_rodada}, 32'h2);
    // iniciar is ignored outside INICIAL and the end states.
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk("iniciar_ignored", {28'd0, bus.db_estado}, 32'h4);

    // 5. Timeout disabled: long idle, then a 50-cycle hold gives one event.
    pulse_reset();
    bus.timeout_en = 1'b0;
    start_game("nt");
    play_range(0, 2, "nt");
    repeat (302) @(negedge clock);
    chk("nt_idle_estado", {28'd0, bus.db_estado}, 32'h4);
    chk_flags("nt_idle_flags", 4'h4);
    bus.botoes = 4'b0001;
    repeat (50) @(posedge clock);
    @(negedge clock);
    bus.botoes = 4'b0000;
    repeat (2) @(negedge clock);
    chk("hold_estado", {28'd0, bus.db_estado}, 32'h4);
    chk("hold_endereco", {30'd0, bus.db_endereco}, 32'h1);
    chk("hold_leds", {28'd0, bus.leds}, 32'h1);
    play(tbl[4], "nt_after_hold");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/jogo_memoria_param.md
Name: jogo_memoria_param

Overview:
Parametrised successor of the lab memory-game controller. It handles N buttons, a sequence depth of P, and a configurable timeout that can be switched on or off at run time. The player builds the sequence one new play per round, and each round must first repeat every stored play. Datapath (sequence RAM, counters, edge detector, timeout counter) and FSM are in one block, which sits directly under the board top level.

Parameters:
N_BOTOES, 4, number of buttons/LEDs; play width.
PROFUNDIDADE, 16, sequence depth P; power of two, >=2. AW = clog2(P).
TIMEOUT_CICLOS, 5000, idle clock cycles allowed in any wait state.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  reset, asynchronous and active-low.
iniciar  in  1  start/restart request, level-sampled.
botoes  in  N_BOTOES  player buttons, active-high.
timeout_en  in  1  1 = timeout enforced; 0 = wait forever.
ganhou  out  1  game won.
perdeu  out  1  game lost (wrong play or timeout).
pronto  out  1  game finished (any end state).
leds  out  N_BOTOES  last accepted play.
db_estado  out  4  FSM state code.
db_rodada  out  AW  current round.
db_endereco  out  AW  current compare address.
db_timeout  out  1  end reason was timeout.

Behaviour:
- reset=0 (async): FSM goes to INICIAL. All outputs, counters and registers go to 0. RAM contents are don't-care. Reset mid-game aborts immediately.
- Edge detect: botoes_reg <= botoes every clock; prev <= |botoes_reg.
  - evento = |botoes_reg & ~prev.
  - A held button produces exactly one evento. Multi-bit values are accepted as-is and compared as-is.
  - evento outside a wait state is discarded.
- States (db_estado code):
  - INICIAL 0: iniciar=1 -> PREPARA.
  - PREPARA 1: rodada=0, endereco=0, leds=0, timer=0 -> ESPERA_PRIMEIRA.
  - ESPERA_PRIMEIRA 2: evento -> GRAVA_PRIMEIRA (jogada <= botoes_reg).
  - GRAVA_PRIMEIRA 3: mem[0] <= jogada -> ESPERA_JOGADA.
  - ESPERA_JOGADA 4: evento -> COMPARA (jogada <= botoes_reg).
  - COMPARA 5:
    - jogada != mem[endereco] -> FIM_PERDEU.
    - Equal and endereco < rodada: endereco++ -> ESPERA_JOGADA.
    - Equal, endereco == rodada, rodada == P-1 -> FIM_GANHOU.
    - Otherwise -> ESPERA_NOVA.
  - ESPERA_NOVA 7: evento -> GRAVA_NOVA (jogada <= botoes_reg).
  - GRAVA_NOVA 8: mem[rodada+1] <= jogada -> PROX_RODADA.
  - PROX_RODADA 9: rodada++, endereco=0 -> ESPERA_JOGADA.
  - FIM_GANHOU A, FIM_PERDEU E, FIM_TIMEOUT F: iniciar=1 -> PREPARA (restart clears all flags).
  - iniciar is ignored in every non-end state except INICIAL.
- Latency: press first sampled at edge t -> state COMPARA after edge t+1 -> end state or next wait state after edge t+2.
- Timeout:
  - Timer clears on entry to each wait state (2, 4, 7) and counts every cycle spent in it.
  - With timeout_en=1 and timer == TIMEOUT_CICLOS-1 with no evento -> FIM_TIMEOUT on the next edge.
  - evento in the same cycle as expiry wins (the play is accepted).
  - timeout_en=0 holds the timer at 0.
- Outputs:
  - pronto=1 in states A/E/F.
  - ganhou=1 only in A.
  - perdeu=1 in E and F.
  - db_timeout=1 only in F.
  - leds updates on every accepted play, holds until the next one or PREPARA.
- Width: rodada/endereco are AW bits and never wrap (rodada saturates at P-1 via FIM_GANHOU). rodada+1 is only used when rodada < P-1.

Test Plan:
1. Pulse reset=0 mid-idle -> all outputs 0, db_estado=0. Repeat during ESPERA_JOGADA -> immediate return to 0.
2. N=4, P=4, TIMEOUT=100, timeout_en=1. Play first entry 0001, then:
   - round0: 0001 + new 0010;
   - round1: 0001,0010 + new 0100;
   - round2: 0001,0010,0100 + new 1000;
   - round3: 0001,0010,0100,1000.
   -> ganhou=1, pronto=1, perdeu=0, db_rodada=3, db_estado=A, two cycles after the last press is sampled.
3. Same sequence, but in round1 press 0100 instead of 0010 at endereco=1 -> perdeu=1, ganhou=0, db_timeout=0, db_estado=E, two cycles after the press.
4. timeout_en=1; reach ESPERA_NOVA in round1 and hold botoes=0 -> FIM_TIMEOUT exactly 100 cycles after entry: perdeu=1, db_timeout=1, db_estado=F. A press on the expiry cycle instead is accepted (state 8).
5. timeout_en=0; idle 300 cycles in ESPERA_JOGADA -> still in state 4; then a correct play proceeds normally. Hold one button 50 cycles -> exactly one evento (endereco advances by 1).
6. From FIM_PERDEU assert iniciar 1 cycle -> PREPARA then state 2, all flags 0, leds=0; a new game then plays to win.
